fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: redirect/stall control, instruction memory port and IF/ID outputs
interface fetch_stage_if;
  logic        pc_sel;
  logic [31:0] alu_target;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;

  modport master (
    input  pc_sel, alu_target, stall, imem_rdata,
    output imem_addr, if_id_pc, if_id_inst, if_id_valid
  );

  modport slave (
    output pc_sel, alu_target, stall, imem_rdata,
    input  imem_addr, if_id_pc, if_id_inst, if_id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC register, HOLD/RUN sequencer and IF/ID register
// Optional flush counter output enabled by macro FETCH_FLUSH_COUNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clock,
  input  logic               reset,
  fetch_stage_if.master      bus
`ifdef FETCH_FLUSH_COUNT_EN
  ,
  output logic [31:0]        flush_count
`endif
);

  typedef enum logic {HOLD, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic        redirect;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    redirect   = 1'b0;
    case (state_q)
      HOLD: begin
        state_d    = RUN;
        if_inst_d  = NOP_INST;
        if_valid_d = 1'b0;
      end
      RUN: begin
        // A redirect wins over stall; the fetched word on the wrong path becomes a bubble.
        if (bus.pc_sel) begin
          redirect   = 1'b1;
          pc_d       = bus.alu_target & 32'hFFFF_FFFC;
          if_pc_d    = pc_q;
          if_inst_d  = NOP_INST;
          if_valid_d = 1'b0;
        end else if (!bus.stall) begin
          pc_d       = pc_q + 32'd4;
          if_pc_d    = pc_q;
          if_inst_d  = bus.imem_rdata;
          if_valid_d = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= HOLD;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_inst_q  <= NOP_INST;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign bus.imem_addr   = pc_q & 32'hFFFF_FFFC;
  assign bus.if_id_pc    = if_pc_q;
  assign bus.if_id_inst  = if_inst_q;
  assign bus.if_id_valid = if_valid_q;

`ifdef FETCH_FLUSH_COUNT_EN
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (redirect && flush_cnt_q != 32'hFFFF_FFFF)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      flush_cnt_q <= 32'h0;
    else
      flush_cnt_q <= flush_cnt_d;
  end

  assign flush_count = flush_cnt_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven scoreboard bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0100_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] MSK = 32'hA5A5_0000;

  logic clock = 1'b0;
  logic reset;
  fetch_stage_if bus ();
`ifdef FETCH_FLUSH_COUNT_EN
  logic [31:0] flush_count;
`endif

  always #5 clock = ~clock;
  assign bus.imem_rdata = bus.imem_addr ^ MSK;

  fetch_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_FLUSH_COUNT_EN
    ,
    .flush_count(flush_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic        ps;
    logic        st;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic [31:0] e_flush;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic ps, input logic st, input logic [31:0] tgt,
                     input logic [31:0] a, input logic [31:0] p, input logic [31:0] i,
                     input logic v, input logic [31:0] f);
    vec_t r;
    r.rst = rst; r.ps = ps; r.st = st; r.tgt = tgt;
    r.e_addr = a; r.e_pc = p; r.e_inst = i; r.e_valid = v; r.e_flush = f;
    vecs.push_back(r);
  endtask

  task automatic apply(input vec_t r, input int idx);
    vec_t e;
    @(negedge clock);
    reset          = r.rst;
    bus.pc_sel     = r.ps;
    bus.stall      = r.st;
    bus.alu_target = r.tgt;
    sb.push_back(r);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty step %0d", idx);
    end else begin
      e = sb.pop_front();
      check("imem_addr",   idx, bus.imem_addr,  e.e_addr);
      check("if_id_pc",    idx, bus.if_id_pc,   e.e_pc);
      check("if_id_inst",  idx, bus.if_id_inst, e.e_inst);
      check("if_id_valid", idx, {31'b0, bus.if_id_valid}, {31'b0, e.e_valid});
      check("addr_low",    idx, {30'b0, bus.imem_addr[1:0]}, 32'h0);
`ifdef FETCH_FLUSH_COUNT_EN
      check("flush_count", idx, flush_count, e.e_flush);
`endif
    end
  endtask

  initial begin
    reset = 1'b1; bus.pc_sel = 1'b0; bus.stall = 1'b0; bus.alu_target = 32'h0;

    // reset together with a redirect request; the redirect must be discarded
    add(1, 1, 0, 32'h0000_0400, RPC, 32'h0, NOP, 0, 0);
    // HOLD edge ignores pc_sel/stall
    add(0, 1, 1, 32'h1234_5678, RPC, 32'h0, NOP, 0, 0);
    add(0, 0, 0, 32'h0, 32'h0100_0004, RPC,          32'hA4A5_0000, 1, 0);
    add(0, 0, 0, 32'h0, 32'h0100_0008, 32'h0100_0004, 32'hA4A5_0004, 1, 0);
    add(0, 0, 1, 32'h0, 32'h0100_0008, 32'h0100_0004, 32'hA4A5_0004, 1, 0);
    add(0, 0, 1, 32'h0, 32'h0100_0008, 32'h0100_0004, 32'hA4A5_0004, 1, 0);
    add(0, 0, 1, 32'h0, 32'h0100_0008, 32'h0100_0004, 32'hA4A5_0004, 1, 0);
    add(0, 0, 0, 32'h0, 32'h0100_000C, 32'h0100_0008, 32'hA4A5_0008, 1, 0);
    add(0, 1, 0, 32'h0100_0203, 32'h0100_0200, 32'h0100_000C, NOP, 0, 1);
    add(0, 0, 0, 32'h0, 32'h0100_0204, 32'h0100_0200, 32'hA4A5_0200, 1, 1);
    // redirect with stall, then back-to-back redirects
    add(0, 1, 1, 32'h0200_0010, 32'h0200_0010, 32'h0100_0204, NOP, 0, 2);
    add(0, 1, 0, 32'h0300_0020, 32'h0300_0020, 32'h0200_0010, NOP, 0, 3);
    add(0, 1, 0, 32'h0300_0041, 32'h0300_0040, 32'h0300_0020, NOP, 0, 4);
    add(0, 0, 0, 32'h0, 32'h0300_0044, 32'h0300_0040, 32'hA6A5_0040, 1, 4);
    // wrap at the top of the address space
    add(0, 1, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0300_0044, NOP, 0, 5);
    add(0, 0, 0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1, 5);
    add(0, 0, 0, 32'h0, 32'h0000_0004, 32'h0000_0000, 32'hA5A5_0000, 1, 5);
    add(0, 0, 1, 32'h0, 32'h0000_0004, 32'h0000_0000, 32'hA5A5_0000, 1, 5);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // reset mid-stall, then a stall during HOLD, then first valid fetch
    vecs.delete();
    add(1, 0, 1, 32'h0, RPC, 32'h0, NOP, 0, 0);
    add(0, 0, 1, 32'h0, RPC, 32'h0, NOP, 0, 0);
    add(0, 0, 0, 32'h0, 32'h0100_0004, RPC, 32'hA4A5_0000, 1, 0);
    // reset mid-redirect sequence
    add(0, 1, 0, 32'h0000_8000, 32'h0000_8000, 32'h0100_0004, NOP, 0, 1);
    add(1, 1, 0, 32'h0000_9000, RPC, 32'h0, NOP, 0, 0);
    add(0, 0, 0, 32'h0, RPC, 32'h0, NOP, 0, 0);
    add(0, 0, 0, 32'h0, 32'h0100_0004, RPC, 32'hA4A5_0000, 1, 0);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 100 + i);

    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
